// File: rtl/pipeline_pkg.sv
// Shared writeback types: the queued register-write entry and the hard-wired zero register.
package pipeline_pkg;

    localparam int WB_AW = 5;
    localparam int WB_DW = 32;

    localparam logic [WB_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [WB_AW-1:0] rd;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wbq_fifo.sv
// In-order circular buffer: up to two pushes (push0 older) and one pop per cycle, 1-cycle latency.
// No internal backpressure: the caller must never push past DEPTH. All entries are exposed oldest-first.
module wbq_fifo
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push0_vld,
    input  wb_entry_t                push0_dat,
    input  logic                     push1_vld,
    input  wb_entry_t                push1_dat,
    input  logic                     pop,
    output wb_entry_t                head_dat,
    output wb_entry_t                age_dat [DEPTH],
    output logic [DEPTH-1:0]         age_vld,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t     mem_q [DEPTH];
    wb_entry_t     mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers are PW bits wide, so wrap modulo DEPTH falls out of the arithmetic.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push0_vld) begin
            mem_d[wr_ptr_d] = push0_dat;
            wr_ptr_d        = wr_ptr_d + 1'b1;
        end
        if (push1_vld) begin
            mem_d[wr_ptr_d] = push1_dat;
            wr_ptr_d        = wr_ptr_d + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push0_vld) + CW'(push1_vld) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_dat[k] = mem_q[rd_ptr_q + PW'(k)];
            age_vld[k] = (CW'(k) < count_q);
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/writeback_queue.sv
// Register-bank writer: ALU/load results queue in order, one bank write per cycle, 1-cycle min latency;
// readiness from registered occupancy (load owns the last slot); WBQ_STATS_EN adds stall/high-water stats.
module writeback_queue
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_rd,
    input  logic [DW-1:0] ld_data,
    output logic [AW-1:0] write_register,
    output logic [DW-1:0] write_data,
    output logic          Reg_write,
    input  logic [AW-1:0] fwd_addr1,
    input  logic [AW-1:0] fwd_addr2,
    output logic          fwd_hit1,
    output logic          fwd_hit2,
    output logic [DW-1:0] fwd_data1,
    output logic [DW-1:0] fwd_data2
`ifdef WBQ_STATS_EN
    ,
    output logic [15:0]             stall_cnt,
    output logic [$clog2(DEPTH):0]  max_occ
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]    count;
    logic [CW-1:0]    free;
    logic             ld_push, alu_push, pop;
    wb_entry_t        ld_ent, alu_ent, head_dat;
    wb_entry_t        age_dat [DEPTH];
    logic [DEPTH-1:0] age_vld;

    logic             reg_write_q, reg_write_d;
    logic [AW-1:0]    write_register_q, write_register_d;
    logic [DW-1:0]    write_data_q, write_data_d;

    assign free = CW'(DEPTH) - count;

    always_comb begin
        ld_ready  = (free >= CW'(1));
        alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !ld_valid);
    end

    // r0 handshakes complete normally but never occupy a slot.
    assign ld_push  = ld_valid  && ld_ready  && (ld_rd  != REG_ZERO);
    assign alu_push = alu_valid && alu_ready && (alu_rd != REG_ZERO);
    assign pop      = (count != '0);
    assign ld_ent   = '{rd: ld_rd,  data: ld_data};
    assign alu_ent  = '{rd: alu_rd, data: alu_data};

    wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push0_vld (ld_push),
        .push0_dat (ld_ent),
        .push1_vld (alu_push),
        .push1_dat (alu_ent),
        .pop       (pop),
        .head_dat  (head_dat),
        .age_dat   (age_dat),
        .age_vld   (age_vld),
        .count     (count)
    );

    always_comb begin
        reg_write_d      = pop;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        if (pop) begin
            write_register_d = head_dat.rd;
            write_data_d     = head_dat.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
        end else begin
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
        end
    end

    assign Reg_write      = reg_write_q;
    assign write_register = write_register_q;
    assign write_data     = write_data_q;

    // Scan oldest to youngest so the last match (closest to the tail) wins.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        if (reg_write_q && (write_register_q == fwd_addr1)) begin
            fwd_hit1  = 1'b1;
            fwd_data1 = write_data_q;
        end
        if (reg_write_q && (write_register_q == fwd_addr2)) begin
            fwd_hit2  = 1'b1;
            fwd_data2 = write_data_q;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (age_vld[k] && (age_dat[k].rd == fwd_addr1)) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = age_dat[k].data;
            end
            if (age_vld[k] && (age_dat[k].rd == fwd_addr2)) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = age_dat[k].data;
            end
        end
        if (fwd_addr1 == REG_ZERO) begin
            fwd_hit1  = 1'b0;
            fwd_data1 = '0;
        end
        if (fwd_addr2 == REG_ZERO) begin
            fwd_hit2  = 1'b0;
            fwd_data2 = '0;
        end
    end

`ifdef WBQ_STATS_EN
    logic [15:0]   stall_cnt_q, stall_cnt_d;
    logic [CW-1:0] max_occ_q, max_occ_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (((alu_valid && !alu_ready) || (ld_valid && !ld_ready)) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        max_occ_d = (count > max_occ_q) ? count : max_occ_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            max_occ_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            max_occ_q   <= max_occ_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign max_occ   = max_occ_q;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: scoreboard of expected bank writes plus a forwarding reference model.
module tb_writeback_queue;
    import pipeline_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, alu_ready, ld_valid, ld_ready;
    logic [AW-1:0] alu_rd, ld_rd, write_register, fwd_addr1, fwd_addr2;
    logic [DW-1:0] alu_data, ld_data, write_data, fwd_data1, fwd_data2;
    logic          Reg_write, fwd_hit1, fwd_hit2;

    always #5 clk = ~clk;

    writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_rd          (ld_rd),
        .ld_data        (ld_data),
        .write_register (write_register),
        .write_data     (write_data),
        .Reg_write      (Reg_write),
        .fwd_addr1      (fwd_addr1),
        .fwd_addr2      (fwd_addr2),
        .fwd_hit1       (fwd_hit1),
        .fwd_hit2       (fwd_hit2),
        .fwd_data1      (fwd_data1),
        .fwd_data2      (fwd_data2)
    );

    wb_entry_t exp_q [$];
    wb_entry_t out_m;
    logic      out_vld_m = 1'b0;
    int        mdl_cnt   = 0;
    int        checks    = 0;
    int        errors    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                         input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad);
        ld_valid  = lv;
        ld_rd     = lrd;
        ld_data   = ld;
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
    endtask

    // Called just after a falling edge with inputs driven; returns at the next falling edge.
    task automatic cycle();
        int   free;
        int   np;
        logic exp_rw;
        #1;
        free = DEPTH - mdl_cnt;
        chk("ld_ready", ld_ready, free >= 1);
        chk("alu_ready", alu_ready, (free >= 2) || (free == 1 && !ld_valid));
        np = 0;
        if (ld_valid && ld_ready && ld_rd != '0) begin
            exp_q.push_back(wb_entry_t'({ld_rd, ld_data}));
            np++;
        end
        if (alu_valid && alu_ready && alu_rd != '0) begin
            exp_q.push_back(wb_entry_t'({alu_rd, alu_data}));
            np++;
        end
        exp_rw  = (mdl_cnt > 0);
        mdl_cnt = mdl_cnt + np - (exp_rw ? 1 : 0);
        @(posedge clk);
        @(negedge clk);
        chk("reg_write", Reg_write, exp_rw);
        out_vld_m = exp_rw;
        if (exp_rw && exp_q.size() > 0) begin
            out_m = exp_q.pop_front();
            chk("write_register", write_register, out_m.rd);
            chk("write_data", write_data, out_m.data);
        end
    endtask

    function automatic void fwd_model(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
        if (a != '0) begin
            if (out_vld_m && out_m.rd == a) begin
                h = 1'b1;
                d = out_m.data;
            end
            foreach (exp_q[i]) begin
                if (exp_q[i].rd == a) begin
                    h = 1'b1;
                    d = exp_q[i].data;
                end
            end
        end
    endfunction

    task automatic chk_fwd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        logic          h;
        logic [DW-1:0] d;
        fwd_addr1 = a1;
        fwd_addr2 = a2;
        #1;
        fwd_model(a1, h, d);
        chk("fwd_hit1", fwd_hit1, h);
        chk("fwd_data1", fwd_data1, d);
        fwd_model(a2, h, d);
        chk("fwd_hit2", fwd_hit2, h);
        chk("fwd_data2", fwd_data2, d);
    endtask

    initial begin
        rst       = 1'b1;
        fwd_addr1 = '0;
        fwd_addr2 = '0;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_reg_write", Reg_write, 0);
        chk("rst_write_register", write_register, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_alu_ready", alu_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // Single ALU write, then idle.
        drive(0, 0, 0, 1, 5, 32'hDEADBEEF);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        chk_fwd(5, 6);
        cycle();

        // Dual push: load is older than ALU.
        drive(1, 3, 32'h11, 1, 4, 32'h22);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk_fwd(3, 4);
        repeat (3) cycle();

        // Sustained pressure from both producers.
        for (int i = 0; i < 10; i++) begin
            drive(1, AW'(1 + (i % 3)), DW'(32'h100 + i), 1, AW'(8 + (i % 2)), DW'(32'h200 + i));
            cycle();
            chk_fwd(AW'(1 + (i % 3)), AW'(8 + (i % 2)));
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (5) cycle();

        // r0 writes complete but never reach the bank.
        drive(1, 0, 32'h66, 1, 0, 32'h55);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk_fwd(0, 0);
        cycle();

        // Youngest pending value wins over the output register.
        drive(0, 0, 0, 1, 7, 32'hA);
        cycle();
        chk_fwd(7, 3);
        drive(0, 0, 0, 1, 7, 32'hB);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk_fwd(7, 7);
        cycle();
        chk_fwd(7, 0);
        cycle();
        chk_fwd(7, 9);

        // Same-cycle producer data is not forwarded; ALU beats load when both target one register.
        drive(1, 9, 32'h1, 1, 9, 32'h2);
        chk_fwd(9, 7);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk_fwd(9, 9);
        repeat (3) cycle();

        // Asynchronous reset with three entries pending.
        drive(1, 10, 32'hA0, 1, 11, 32'hB0);
        cycle();
        drive(0, 0, 0, 1, 12, 32'hC0);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_reg_write", Reg_write, 0);
        chk("mid_rst_ld_ready", ld_ready, 1);
        chk("mid_rst_alu_ready", alu_ready, 1);
        chk("mid_rst_write_register", write_register, 0);
        exp_q.delete();
        mdl_cnt   = 0;
        out_vld_m = 1'b0;
        chk_fwd(11, 12);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) cycle();
        chk_fwd(10, 12);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Writer side of the 32x32 register bank port (write_register / write_data / Reg_write), placed at the end of the writeback stage.
- Accepts results from two producers, the ALU path and the load path, over valid/ready handshakes.
- Buffers results in an in-order FIFO and drains one write per cycle into the bank.
- Forwards pending (not yet committed) values to the two decode read addresses so decode never consumes stale bank data.

Parameters:
DEPTH, 4, FIFO entries (power of 2, ≥2)
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
alu_valid  in  1  ALU result offered
alu_ready  out  1  ALU result accepted when alu_valid & alu_ready
alu_rd  in  AW  ALU destination register
alu_data  in  DW  ALU result
ld_valid  in  1  load result offered
ld_ready  out  1  load accepted when ld_valid & ld_ready
ld_rd  in  AW  load destination register
ld_data  in  DW  load data
write_register  out  AW  to bank write address
write_data  out  DW  to bank write data
Reg_write  out  1  to bank write enable
fwd_addr1  in  AW  decode read address 1
fwd_addr2  in  AW  decode read address 2
fwd_hit1  out  1  pending value exists for fwd_addr1
fwd_hit2  out  1  pending value exists for fwd_addr2
fwd_data1  out  DW  youngest pending value for fwd_addr1
fwd_data2  out  DW  youngest pending value for fwd_addr2

Behaviour:
- Reset (async): pointers and count = 0; Reg_write = 0, write_register = 0, write_data = 0. Producers must not assert valid during reset.
- Readiness (combinational from registered count):
  - free = DEPTH - count.
  - ld_ready = (free ≥ 1).
  - alu_ready = (free ≥ 2) | (free == 1 & !ld_valid).
  - Load has priority for the last slot.
- Enqueue order, same cycle: load entry first (older), then ALU. Up to two enqueues per cycle.
- Register 0 filter: a handshake with rd == 0 completes but writes no entry and uses no slot. Readiness is still computed as above.
- Drain:
  - Each cycle with count > 0 (pre-enqueue value), the head pops into the output registers; Reg_write = 1 in the next cycle.
  - Otherwise Reg_write = 0, and write_register / write_data hold their last values.
  - Minimum latency: handshake at edge N, Reg_write high during cycle N+1 (entry enters FIFO at edge N, pops at edge N+1). A filtered or empty queue yields no write.
- Count update: count_next = count + enqueues − pop. Enqueue and pop in the same cycle at count == DEPTH is allowed only through free computed pre-pop, so the FIFO never overflows.
- Pointer wrap: modulo DEPTH.
- Forwarding (combinational):
  - Search set: the output-register entry (when Reg_write = 1, not yet written by the bank) plus all valid FIFO entries.
  - The youngest matching entry wins; the FIFO tail side beats the output register.
  - fwd_addr == 0: hit = 0, data = 0.
  - No match: hit = 0, data = 0.
  - Same-cycle incoming producer data is NOT forwarded.

Optional Feature:
- WBQ_STATS_EN defined:
  - Adds outputs stall_cnt [15:0] and max_occ [$clog2(DEPTH):0].
  - stall_cnt increments each cycle that (alu_valid & !alu_ready) | (ld_valid & !ld_ready); it saturates at 0xFFFF.
  - max_occ is the high-water mark of count.
  - Both are cleared by rst.
- Undefined: neither port nor logic exists.

Decomposition:
- Shared package pipeline_pkg: wb_entry_t {rd[AW], data[DW]} and constant REG_ZERO = 0.
- One sub-module, wbq_fifo: dual-push / single-pop circular buffer that exposes all entries and their valid bits for the forward search.
- Arbitration, filter, output registers and forwarding stay in the top.

Test Plan:
- Single ALU write: after reset, alu rd=5 data=0xDEADBEEF for 1 cycle -> next cycle Reg_write=1, write_register=5, write_data=0xDEADBEEF; then Reg_write=0.
- Dual push: ld rd=3 0x11 and alu rd=4 0x22 in the same cycle -> writes to r3 then r4 on consecutive cycles.
- Full/backpressure: hold alu_valid and ld_valid with rd≠0 continuously -> count never exceeds 4; ld_ready is high whenever free==1; alu_ready drops.
- r0 filter: alu rd=0 data=0x55 -> handshake completes; no Reg_write; fwd_addr1=0 gives hit=0.
- Forward priority: enqueue rd=7 0xA then rd=7 0xB -> with fwd_addr1=7, fwd_data1=0xB until 0xB is committed.
- Async reset mid-drain: assert rst with 3 entries pending -> Reg_write=0 immediately; no writes after release; all ready signals high.
